// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO deserializer.
// SIPO_PARITY_CHECK_EN adds one even-parity bit per frame.
package sipo_pkg;

  typedef enum logic {
    SIPO_IDLE,
    SIPO_SHIFT
  } sipo_state_e;

  function automatic int frame_bits(input int width);
`ifdef SIPO_PARITY_CHECK_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bundle between stream source and deserializer.
// parity_err exists only when SIPO_PARITY_CHECK_EN is defined.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             sync;
  logic             serial_in;
  logic             serial_valid;
  logic [WIDTH-1:0] parallel_out;
  logic             word_valid;
  logic             busy;
`ifdef SIPO_PARITY_CHECK_EN
  logic             parity_err;

  modport master (
    output sync, serial_in, serial_valid,
    input  parallel_out, word_valid, busy,
    input  parity_err
  );

  modport slave (
    input  sync, serial_in, serial_valid,
    output parallel_out, word_valid, busy,
    output parity_err
  );
`else
  modport master (
    output sync, serial_in, serial_valid,
    input  parallel_out, word_valid, busy
  );

  modport slave (
    input  sync, serial_in, serial_valid,
    output parallel_out, word_valid, busy
  );
`endif
endinterface

// File: rtl/sipo_bit_counter.sv
// Modulo-FRAME_BITS bit position counter.
// load has priority over en and restarts the count at 0 or 1.
module sipo_bit_counter #(
  parameter int FRAME_BITS = 4,
  parameter int CW = $clog2(FRAME_BITS)
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          en,
  input  logic          load,
  input  logic          load_one,
  output logic [CW-1:0] cnt,
  output logic          last_bit
);

  assign last_bit = (cnt == CW'(FRAME_BITS - 1));

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_one ? CW'(1) : '0;
    end else if (en) begin
      cnt <= last_bit ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel front end for the PIPO storage stage.
// SIPO_PARITY_CHECK_EN appends an even-parity bit to every frame.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               clear_n,
  sipo_deserializer_if.slave bus
);

  localparam int FRAME_BITS = frame_bits(WIDTH);
  localparam int CW = $clog2(FRAME_BITS);

  sipo_state_e      state;
  sipo_state_e      state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic             last_bit;
  logic             shift_en;
  logic             done;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] data_word;
  logic [WIDTH-1:0] pout_q;
  logic             wv_q;

  assign shift_en = bus.serial_valid & ~bus.sync;
  assign done     = shift_en & last_bit;

  sipo_bit_counter #(
    .FRAME_BITS (FRAME_BITS),
    .CW         (CW)
  ) u_cnt (
    .clk      (clk),
    .clear_n  (clear_n),
    .en       (shift_en),
    .load     (bus.sync),
    .load_one (bus.serial_valid),
    .cnt      (bit_cnt),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= SIPO_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      bus.sync: begin
        state_nxt = bus.serial_valid ? SIPO_SHIFT
                                     : SIPO_IDLE;
      end
      shift_en: begin
        state_nxt = last_bit ? SIPO_IDLE
                             : SIPO_SHIFT;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy = (state == SIPO_SHIFT);
  end

`ifdef SIPO_PARITY_CHECK_EN
  logic perr_q;

  // Last bit of the frame is parity; data is already in shreg.
  assign data_word = shreg;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= done & (^{shreg, bus.serial_in});
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign data_word = {shreg[WIDTH-2:0], bus.serial_in};
`endif

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      shreg <= '0;
    end else if (bus.sync) begin
      shreg <= bus.serial_valid
             ? {{(WIDTH-1){1'b0}}, bus.serial_in}
             : '0;
    end else if (shift_en) begin
      shreg <= {shreg[WIDTH-2:0], bus.serial_in};
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      pout_q <= '0;
      wv_q   <= 1'b0;
    end else begin
      wv_q <= done;
      if (done) begin
        pout_q <= data_word;
      end
    end
  end

  assign bus.parallel_out = pout_q;
  assign bus.word_valid   = wv_q;

endmodule
